// File: rtl/rv32i_top.sv
// Single-cycle RV32I core with internal instruction memory, register file and data memory.
// Each instruction fetches, executes and writes back in one clock cycle.

module inst_memory #(
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     load_en,
  input  logic [$clog2(WORDS)-1:0] load_index,
  input  logic [31:0]              load_word,
  input  logic [31:0]              addr,
  output logic [31:0]              instr
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] memory [0:WORDS-1];
  logic        unused_addr_bits;

  // Program image is normally preloaded; the load port lets a host fill it word by word.
  always_ff @(posedge clk) begin
    if (load_en) memory[load_index] <= load_word;
  end

  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
  assign instr = memory[addr[AW+1:2]];
endmodule

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  input  logic        WE3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (!reset && WE3 && (A3 != 5'd0)) registers[A3] <= WD3;
  end

  assign RD1 = (A1 == 5'd0) ? 32'd0 : registers[A1];
  assign RD2 = (A2 == 5'd0) ? 32'd0 : registers[A2];
endmodule

module data_memory #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [3:0]  BE,
  output logic [31:0] RD
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] memory [0:WORDS-1];
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{A[31:AW+2], A[1:0]};

  // WD arrives already lane-positioned; BE selects which lanes are committed.
  always_ff @(posedge clk) begin
    if (!reset && WE) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) memory[A[AW+1:2]][8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

  assign RD = memory[A[AW+1:2]];
endmodule

module rv32i_top #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, pc_plus4, next_pc, instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rd1, rd2, alu_b, alu_result, sra_result;
  logic [31:0] data_addr, read_word, load_data, store_data, reg_wd;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [3:0]  byte_en;
  logic        reg_write, mem_write, branch_taken;

  inst_memory #(.WORDS(IMEM_WORDS)) inst_memory (
    .clk(clk), .load_en(1'b0), .load_index('0), .load_word(32'd0),
    .addr(pc), .instr(instr)
  );

  reg_file reg_file (
    .clk(clk), .reset(reset), .A1(rs1), .A2(rs2), .A3(rd), .WD3(reg_wd),
    .WE3(reg_write), .RD1(rd1), .RD2(rd2)
  );

  data_memory #(.WORDS(DMEM_WORDS)) data_memory (
    .clk(clk), .reset(reset), .A(data_addr), .WD(store_data), .WE(mem_write),
    .BE(byte_en), .RD(read_word)
  );

  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= next_pc;
  end

  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7_b5 = instr[30];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Kept as its own signal so the arithmetic shift is not turned logical by a mixed-sign mux.
  assign alu_b      = (opcode == OP_REG) ? rd2 : imm_i;
  assign sra_result = $signed(rd1) >>> alu_b[4:0];

  always_comb begin
    alu_result = 32'd0;
    case (funct3)
      3'b000:  alu_result = (opcode == OP_REG && funct7_b5) ? rd1 - alu_b : rd1 + alu_b;
      3'b001:  alu_result = rd1 << alu_b[4:0];
      3'b010:  alu_result = {31'd0, $signed(rd1) < $signed(alu_b)};
      3'b011:  alu_result = {31'd0, rd1 < alu_b};
      3'b100:  alu_result = rd1 ^ alu_b;
      3'b101:  alu_result = funct7_b5 ? sra_result : rd1 >> alu_b[4:0];
      3'b110:  alu_result = rd1 | alu_b;
      default: alu_result = rd1 & alu_b;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rd1 == rd2);
      3'b001:  branch_taken = (rd1 != rd2);
      3'b100:  branch_taken = ($signed(rd1) <  $signed(rd2));
      3'b101:  branch_taken = ($signed(rd1) >= $signed(rd2));
      3'b110:  branch_taken = (rd1 <  rd2);
      3'b111:  branch_taken = (rd1 >= rd2);
      default: branch_taken = 1'b0;
    endcase
  end

  assign data_addr = rd1 + ((opcode == OP_STORE) ? imm_s : imm_i);

  // Narrow stores replicate the data across lanes and let byte_en pick the target lane.
  always_comb begin
    store_data = rd2;
    byte_en    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{rd2[7:0]}};
        byte_en    = 4'b0001 << data_addr[1:0];
      end
      2'b01: begin
        store_data = {2{rd2[15:0]}};
        byte_en    = data_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign load_byte = read_word[{data_addr[1:0], 3'b000} +: 8];
  assign load_half = data_addr[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = read_word;
    endcase
  end

  // Anything not decoded here (FENCE, SYSTEM, unknown) falls through as a NOP.
  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    reg_wd    = alu_result;
    next_pc   = pc_plus4;
    case (opcode)
      OP_LUI: begin
        reg_write = 1'b1;
        reg_wd    = imm_u;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        reg_wd    = pc + imm_u;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        reg_wd    = pc_plus4;
        next_pc   = pc + imm_j;
      end
      OP_JALR: begin
        reg_write = 1'b1;
        reg_wd    = pc_plus4;
        next_pc   = (rd1 + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (branch_taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        reg_wd    = load_data;
      end
      OP_STORE: begin
        mem_write = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OP_IMM, OP_REG: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rv32i_top.sv
// Directed bench for rv32i_top: per-instruction vector table plus hand-written programs
// for stores/loads, control flow, x0 handling and mid-program reset.

module tb_rv32i_top;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [31:0] HALT     = 32'h0000006F;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  typedef enum {VEC_ALU, VEC_BRANCH} vec_kind_e;
  typedef struct {
    string       name;
    vec_kind_e   kind;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
  } vector_t;

  vector_t vectors[$];

  rv32i_top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .reset(reset));

  always #10 clk = ~clk;

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // lui/addi pair; the +0x800 rounding compensates for addi sign-extending its immediate.
  function automatic logic [31:0] luiFor(input logic [31:0] v, input logic [4:0] rd);
    logic [31:0] rounded;
    rounded = v + 32'h800;
    return encU(rounded[31:12], rd, OP_LUI);
  endfunction

  function automatic logic [31:0] addiFor(input logic [31:0] v, input logic [4:0] rd);
    return encI(v[11:0], rd, 3'b000, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] regValue(input logic [4:0] idx);
    return dut.reg_file.registers[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadProgram(input logic [31:0] prog[$]);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++)
      dut.inst_memory.memory[i] = (i < prog.size()) ? prog[i] : HALT;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v);
    logic [31:0] prog[$];
    prog.push_back(luiFor(v.a, 5'd5));
    prog.push_back(addiFor(v.a, 5'd5));
    prog.push_back(luiFor(v.b, 5'd6));
    prog.push_back(addiFor(v.b, 5'd6));
    prog.push_back(encI(12'd2, 5'd0, 3'b000, 5'd7, OP_IMM));
    prog.push_back(v.instr);
    if (v.kind == VEC_BRANCH) prog.push_back(encI(12'd1, 5'd0, 3'b000, 5'd7, OP_IMM));
    prog.push_back(HALT);
    loadProgram(prog);
    runCycles(10);
  endtask

  task automatic fillVectors();
    vectors.push_back('{"add",       VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 32'd5,        32'd7,        32'd12});
    vectors.push_back('{"add_wrap",  VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 32'h7FFFFFFF, 32'd1,        32'h80000000});
    vectors.push_back('{"sub",       VEC_ALU, encR(7'h20, 5'd6, 5'd5, 3'b000, 5'd7), 32'd3,        32'd5,        32'hFFFFFFFE});
    vectors.push_back('{"sll_33",    VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b001, 5'd7), 32'd1,        32'd33,       32'd2});
    vectors.push_back('{"slt",       VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b010, 5'd7), 32'hFFFFFFFF, 32'd1,        32'd1});
    vectors.push_back('{"sltu",      VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b011, 5'd7), 32'hFFFFFFFF, 32'd1,        32'd0});
    vectors.push_back('{"xor",       VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b100, 5'd7), 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00});
    vectors.push_back('{"srl",       VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b101, 5'd7), 32'hFFFFFFF8, 32'd1,        32'h7FFFFFFC});
    vectors.push_back('{"sra",       VEC_ALU, encR(7'h20, 5'd6, 5'd5, 3'b101, 5'd7), 32'hFFFFFFF8, 32'd1,        32'hFFFFFFFC});
    vectors.push_back('{"or",        VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b110, 5'd7), 32'h12340000, 32'h00005678, 32'h12345678});
    vectors.push_back('{"and",       VEC_ALU, encR(7'h00, 5'd6, 5'd5, 3'b111, 5'd7), 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00});
    vectors.push_back('{"addi_neg",  VEC_ALU, encI(12'hFFF, 5'd5, 3'b000, 5'd7, OP_IMM), 32'd0,        32'd0, 32'hFFFFFFFF});
    vectors.push_back('{"slti",      VEC_ALU, encI(12'hFFF, 5'd5, 3'b010, 5'd7, OP_IMM), 32'hFFFFFFFE, 32'd0, 32'd1});
    vectors.push_back('{"sltiu",     VEC_ALU, encI(12'hFFF, 5'd5, 3'b011, 5'd7, OP_IMM), 32'd5,        32'd0, 32'd1});
    vectors.push_back('{"xori",      VEC_ALU, encI(12'hFFF, 5'd5, 3'b100, 5'd7, OP_IMM), 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0});
    vectors.push_back('{"ori",       VEC_ALU, encI(12'h0FF, 5'd5, 3'b110, 5'd7, OP_IMM), 32'h00000100, 32'd0, 32'h000001FF});
    vectors.push_back('{"andi",      VEC_ALU, encI(12'h0F0, 5'd5, 3'b111, 5'd7, OP_IMM), 32'h12345678, 32'd0, 32'h00000070});
    vectors.push_back('{"slli",      VEC_ALU, encI(12'h01F, 5'd5, 3'b001, 5'd7, OP_IMM), 32'd1,        32'd0, 32'h80000000});
    vectors.push_back('{"srli",      VEC_ALU, encI(12'h004, 5'd5, 3'b101, 5'd7, OP_IMM), 32'h80000000, 32'd0, 32'h08000000});
    vectors.push_back('{"srai",      VEC_ALU, encI(12'h404, 5'd5, 3'b101, 5'd7, OP_IMM), 32'h80000000, 32'd0, 32'hF8000000});
    vectors.push_back('{"lui",       VEC_ALU, encU(20'hABCDE, 5'd7, OP_LUI),             32'd0,        32'd0, 32'hABCDE000});
    vectors.push_back('{"beq_taken", VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b000), 32'd5,        32'd5, 32'd2});
    vectors.push_back('{"bne_not",   VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b001), 32'd5,        32'd5, 32'd1});
    vectors.push_back('{"blt_taken", VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b100), 32'hFFFFFFFF, 32'd1, 32'd2});
    vectors.push_back('{"bge_not",   VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b101), 32'hFFFFFFFF, 32'd1, 32'd1});
    vectors.push_back('{"bge_equal", VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b101), 32'd1,        32'd1, 32'd2});
    vectors.push_back('{"bltu_not",  VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b110), 32'hFFFFFFFF, 32'd1, 32'd1});
    vectors.push_back('{"bgeu_tkn",  VEC_BRANCH, encB(13'd8, 5'd6, 5'd5, 3'b111), 32'hFFFFFFFF, 32'd1, 32'd2});
  endtask

  task automatic testHarris();
    logic [31:0] prog[$];
    logic        found;
    prog = {32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
            32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
            32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
            32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
            32'h00210063};
    loadProgram(prog);
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (dut.data_memory.WE && dut.data_memory.A[31:2] == 30'd25 && dut.data_memory.WD == 32'd25)
        found = 1'b1;
      else
        @(negedge clk);
    end
    checkOutput("harris_store_seen", {31'd0, found}, 32'd1);
    runCycles(2);
    checkOutput("harris_mem_word25", dut.data_memory.memory[25], 32'd25);
  endtask

  task automatic testLoop();
    logic [31:0] prog[$];
    logic        found;
    prog.push_back(encI(12'd0, 5'd0, 3'b000, 5'd10, OP_IMM));
    prog.push_back(encI(12'd7, 5'd0, 3'b000, 5'd11, OP_IMM));
    prog.push_back(encI(12'd1, 5'd10, 3'b000, 5'd10, OP_IMM));
    prog.push_back(encI(12'hFFF, 5'd11, 3'b000, 5'd11, OP_IMM));
    prog.push_back(encB(13'h1FF8, 5'd0, 5'd11, 3'b001));
    prog.push_back(HALT);
    loadProgram(prog);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (dut.reg_file.WE3 && dut.reg_file.A3 == 5'd10 && dut.reg_file.WD3 == 32'd7)
        found = 1'b1;
      else
        @(negedge clk);
    end
    checkOutput("loop_write_x10_7", {31'd0, found}, 32'd1);
    runCycles(4);
    checkOutput("loop_x10", regValue(5'd10), 32'd7);
    checkOutput("loop_x11", regValue(5'd11), 32'd0);
    checkOutput("loop_halt_pc", dut.pc, 32'h14);
  endtask

  task automatic testReset();
    logic [31:0] prog[$];
    prog.push_back(encI(12'd0, 5'd0, 3'b000, 5'd20, OP_IMM));
    prog.push_back(encI(12'h055, 5'd0, 3'b000, 5'd21, OP_IMM));
    prog.push_back(encS(12'd128, 5'd21, 5'd0, 3'b010));
    prog.push_back(HALT);
    loadProgram(prog);
    runCycles(6);
    checkOutput("rst_setup_mem", dut.data_memory.memory[32], 32'h55);

    prog.delete();
    prog.push_back(encI(12'd1, 5'd20, 3'b000, 5'd20, OP_IMM));
    prog.push_back(encS(12'd128, 5'd20, 5'd0, 3'b010));
    prog.push_back(HALT);
    loadProgram(prog);
    checkOutput("rst_pc_after_reset", dut.pc, 32'd0);
    runCycles(1);
    checkOutput("rst_first_addi", regValue(5'd20), 32'd1);
    checkOutput("rst_pc_before", dut.pc, 32'd4);
    reset = 1'b1;
    runCycles(1);
    checkOutput("rst_pc_edge1", dut.pc, 32'd0);
    checkOutput("rst_sw_suppressed", dut.data_memory.memory[32], 32'h55);
    runCycles(1);
    checkOutput("rst_pc_edge2", dut.pc, 32'd0);
    checkOutput("rst_addi_suppressed", regValue(5'd20), 32'd1);
    reset = 1'b0;
    runCycles(2);
    checkOutput("rst_rerun_x20", regValue(5'd20), 32'd2);
    checkOutput("rst_rerun_mem", dut.data_memory.memory[32], 32'd2);
    runCycles(2);
    checkOutput("rst_rerun_pc", dut.pc, 32'h8);
  endtask

  task automatic testMemory();
    logic [31:0] prog[$];
    prog.push_back(encU(20'h12345, 5'd1, OP_LUI));
    prog.push_back(encI(12'h678, 5'd1, 3'b000, 5'd1, OP_IMM));
    prog.push_back(encI(12'h040, 5'd0, 3'b000, 5'd2, OP_IMM));
    prog.push_back(encS(12'd0, 5'd1, 5'd2, 3'b010));
    prog.push_back(encI(12'h0A5, 5'd0, 3'b000, 5'd3, OP_IMM));
    prog.push_back(encS(12'd1, 5'd3, 5'd2, 3'b000));
    prog.push_back(encI(12'd1, 5'd2, 3'b000, 5'd4, OP_LOAD));
    prog.push_back(encI(12'd1, 5'd2, 3'b100, 5'd5, OP_LOAD));
    prog.push_back(encI(12'd0, 5'd2, 3'b010, 5'd6, OP_LOAD));
    prog.push_back(encI(12'd0, 5'd2, 3'b001, 5'd7, OP_LOAD));
    prog.push_back(encI(12'd2, 5'd2, 3'b101, 5'd8, OP_LOAD));
    prog.push_back(encU(20'h00001, 5'd9, OP_AUIPC));
    prog.push_back(encS(12'd2, 5'd3, 5'd2, 3'b001));
    prog.push_back(encI(12'd0, 5'd2, 3'b010, 5'd10, OP_LOAD));
    prog.push_back(HALT);
    loadProgram(prog);
    runCycles(20);
    checkOutput("mem_lb",    regValue(5'd4),  32'hFFFFFFA5);
    checkOutput("mem_lbu",   regValue(5'd5),  32'h000000A5);
    checkOutput("mem_lw",    regValue(5'd6),  32'h1234A578);
    checkOutput("mem_lh",    regValue(5'd7),  32'hFFFFA578);
    checkOutput("mem_lhu",   regValue(5'd8),  32'h00001234);
    checkOutput("mem_auipc", regValue(5'd9),  32'h0000102C);
    checkOutput("mem_sh_lw", regValue(5'd10), 32'h00A5A578);
    checkOutput("mem_word",  dut.data_memory.memory[16], 32'h00A5A578);
  endtask

  task automatic testControl();
    logic [31:0] prog[$];
    prog.push_back(encI(12'd9, 5'd0, 3'b000, 5'd1, OP_IMM));
    prog.push_back(32'h000000FF);
    prog.push_back(encI(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM));
    prog.push_back(encR(7'h00, 5'd0, 5'd0, 3'b000, 5'd1));
    prog.push_back(HALT);
    loadProgram(prog);
    runCycles(2);
    checkOutput("unknown_op_nop_x1", regValue(5'd1), 32'd9);
    checkOutput("unknown_op_pc", dut.pc, 32'h8);
    runCycles(4);
    checkOutput("x0_stays_zero", regValue(5'd1), 32'd0);

    prog.delete();
    prog.push_back(encJ(21'd8, 5'd1));
    prog.push_back(encI(12'd1, 5'd0, 3'b000, 5'd2, OP_IMM));
    prog.push_back(encI(12'h011, 5'd1, 3'b000, 5'd3, 7'b1100111));
    prog.push_back(HALT);
    prog.push_back(HALT);
    prog.push_back(HALT);
    loadProgram(prog);
    runCycles(1);
    checkOutput("jal_pc", dut.pc, 32'h8);
    checkOutput("jal_link", regValue(5'd1), 32'h4);
    runCycles(1);
    checkOutput("jalr_pc", dut.pc, 32'h14);
    checkOutput("jalr_link", regValue(5'd3), 32'hC);
    runCycles(3);
    checkOutput("jal_skipped", regValue(5'd2), 32'h40);
  endtask

  initial begin
    reset = 1'b1;
    fillVectors();
    $display("[TB] running %0d instruction vectors", vectors.size());
    foreach (vectors[i]) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("vec_%s", vectors[i].name), regValue(5'd7), vectors[i].expected);
    end
    testHarris();
    testLoop();
    testReset();
    testMemory();
    testControl();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
